yuv422_to_rgb: RTL and testbench

YUV422_TO_RGB -- requirements
Module: yuv422_to_rgb

---
 rtl/yuv422_to_rgb_if.sv | 19 +
 rtl/yuv422_to_rgb.sv | 127 ++++++++++++
 tb/tb_yuv422_to_rgb.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/yuv422_to_rgb_if.sv
// Ready/valid bundle for the YUV422 -> RGB888 converter: a 64-bit YUV beat in, a 96-bit RGB beat out.
interface yuv422_to_rgb_if;
    logic [63:0] yuv_i;
    logic        yuv_valid_i;
    logic        yuv_ready_o;
    logic [95:0] rgb_o;
    logic        rgb_valid_o;
    logic        rgb_ready_i;

    modport slave (
        input  yuv_i, yuv_valid_i, rgb_ready_i,
        output yuv_ready_o, rgb_o, rgb_valid_o
    );

    modport master (
        output yuv_i, yuv_valid_i, rgb_ready_i,
        input  yuv_ready_o, rgb_o, rgb_valid_o
    );
endinterface

// File: rtl/yuv422_to_rgb.sv
// Four-pixel YUV422 to RGB888 converter (BT.601, full or studio swing).
// Three-stage pipeline (products, sums, clipped outputs) sharing one global advance.
module yuv422_to_rgb #(
    parameter int LIMITED_RANGE = 0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    yuv422_to_rgb_if.slave        bus
);

    localparam logic signed [19:0] K_C  = (LIMITED_RANGE != 0) ? 20'sd298 : 20'sd256;
    localparam logic signed [19:0] K_RV = (LIMITED_RANGE != 0) ? 20'sd409 : 20'sd359;
    localparam logic signed [19:0] K_GU = (LIMITED_RANGE != 0) ? 20'sd100 : 20'sd88;
    localparam logic signed [19:0] K_GV = (LIMITED_RANGE != 0) ? 20'sd208 : 20'sd183;
    localparam logic signed [19:0] K_BU = (LIMITED_RANGE != 0) ? 20'sd516 : 20'sd454;
    localparam logic signed [19:0] Y_OFF = (LIMITED_RANGE != 0) ? 20'sd16 : 20'sd0;
    localparam logic signed [19:0] ROUND = 20'sd128;

    function automatic logic signed [19:0] luma(input logic [7:0] y);
        return $signed({12'd0, y}) - Y_OFF;
    endfunction

    function automatic logic signed [19:0] chroma(input logic [7:0] c);
        return $signed({12'd0, c}) - 20'sd128;
    endfunction

    // Floor shift then saturate to 0..255.
    function automatic logic [7:0] clip8(input logic signed [19:0] x);
        logic signed [19:0] s;
        s = x >>> 8;
        if (s < 20'sd0)
            return 8'd0;
        else if (s > 20'sd255)
            return 8'hFF;
        return s[7:0];
    endfunction

    logic advance;
    assign advance         = ~bus.rgb_valid_o | bus.rgb_ready_i;
    assign bus.yuv_ready_o = advance;

    logic signed [19:0] yc_d [4];
    logic signed [19:0] rv_d [2];
    logic signed [19:0] gu_d [2];
    logic signed [19:0] gv_d [2];
    logic signed [19:0] bu_d [2];

    logic signed [19:0] yc1 [4];
    logic signed [19:0] rv1 [2];
    logic signed [19:0] gu1 [2];
    logic signed [19:0] gv1 [2];
    logic signed [19:0] bu1 [2];
    logic               v1;

    logic signed [19:0] r_d [4];
    logic signed [19:0] g_d [4];
    logic signed [19:0] b_d [4];

    logic signed [19:0] r2 [4];
    logic signed [19:0] g2 [4];
    logic signed [19:0] b2 [4];
    logic               v2;

    logic [95:0] rgb_d;
    logic [95:0] rgb_q;
    logic        v3;

    // Pixels 0/1 share (U0,V0); pixels 2/3 share (U2,V2).
    always_comb begin
        for (int unsigned k = 0; k < 4; k++)
            yc_d[k] = K_C * luma(bus.yuv_i[63 - 16*k -: 8]);
        for (int unsigned p = 0; p < 2; p++) begin
            rv_d[p] = K_RV * chroma(bus.yuv_i[39 - 32*p -: 8]);
            gu_d[p] = K_GU * chroma(bus.yuv_i[55 - 32*p -: 8]);
            gv_d[p] = K_GV * chroma(bus.yuv_i[39 - 32*p -: 8]);
            bu_d[p] = K_BU * chroma(bus.yuv_i[55 - 32*p -: 8]);
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            r_d[k] = yc1[k] + rv1[k >> 1] + ROUND;
            g_d[k] = yc1[k] - gu1[k >> 1] - gv1[k >> 1] + ROUND;
            b_d[k] = yc1[k] + bu1[k >> 1] + ROUND;
        end
    end

    always_comb begin
        rgb_d = '0;
        for (int unsigned k = 0; k < 4; k++)
            rgb_d[95 - 24*k -: 24] = {clip8(r2[k]), clip8(g2[k]), clip8(b2[k])};
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            yc1   <= '{default: '0};
            rv1   <= '{default: '0};
            gu1   <= '{default: '0};
            gv1   <= '{default: '0};
            bu1   <= '{default: '0};
            r2    <= '{default: '0};
            g2    <= '{default: '0};
            b2    <= '{default: '0};
            rgb_q <= '0;
            v1    <= 1'b0;
            v2    <= 1'b0;
            v3    <= 1'b0;
        end else if (advance) begin
            yc1   <= yc_d;
            rv1   <= rv_d;
            gu1   <= gu_d;
            gv1   <= gv_d;
            bu1   <= bu_d;
            v1    <= bus.yuv_valid_i;
            r2    <= r_d;
            g2    <= g_d;
            b2    <= b_d;
            v2    <= v1;
            rgb_q <= rgb_d;
            v3    <= v2;
        end
    end

    assign bus.rgb_o       = rgb_q;
    assign bus.rgb_valid_o = v3;

endmodule

// File: tb/tb_yuv422_to_rgb.sv
// Directed bench for yuv422_to_rgb (full-swing): reset, conversion/clipping vectors,
// stalled back-to-back stream and mid-stream reset, with hand-computed expectations.
module tb_yuv422_to_rgb;

    logic clk_i = 1'b0;
    logic reset_i;
    int   vectors = 0;
    int   miscompares = 0;

    yuv422_to_rgb_if bus ();

    yuv422_to_rgb #(.LIMITED_RANGE(0)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        return {r, g, b};
    endfunction

    // Neutral chroma makes every channel equal to its pixel's Y.
    function automatic logic [63:0] beat_yuv(input int i);
        logic [7:0] base;
        base = 8'(i * 16);
        return {base + 8'd1, 8'h80, base + 8'd2, 8'h80, base + 8'd3, 8'h80, base + 8'd4, 8'h80};
    endfunction

    function automatic logic [95:0] beat_rgb(input int i);
        logic [7:0] base;
        base = 8'(i * 16);
        return {{3{base + 8'd1}}, {3{base + 8'd2}}, {3{base + 8'd3}}, {3{base + 8'd4}}};
    endfunction

    task automatic send_check(input string tag, input logic [63:0] yuv, input logic [95:0] exp);
        bus.yuv_i       = yuv;
        bus.yuv_valid_i = 1'b1;
        bus.rgb_ready_i = 1'b1;
        #1;
        chk({tag, "_ready"}, 96'(bus.yuv_ready_o), 96'd1);
        step();
        bus.yuv_valid_i = 1'b0;
        chk({tag, "_lat1"}, 96'(bus.rgb_valid_o), 96'd0);
        step();
        chk({tag, "_lat2"}, 96'(bus.rgb_valid_o), 96'd0);
        step();
        chk({tag, "_valid"}, 96'(bus.rgb_valid_o), 96'd1);
        chk({tag, "_data"}, bus.rgb_o, exp);
        step();
        chk({tag, "_drain"}, 96'(bus.rgb_valid_o), 96'd0);
    endtask

    initial begin
        logic [15:0] rpat;
        logic [95:0] held;
        logic        stall_prev;
        int          sent;
        int          recv;

        reset_i         = 1'b1;
        bus.yuv_i       = {8{8'h80}};
        bus.yuv_valid_i = 1'b1;
        bus.rgb_ready_i = 1'b1;
        step();
        step();
        chk("rst_rgb", bus.rgb_o, 96'd0);
        chk("rst_valid", 96'(bus.rgb_valid_o), 96'd0);
        chk("rst_ready", 96'(bus.yuv_ready_o), 96'd1);
        reset_i         = 1'b0;
        bus.yuv_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_discard", 96'(bus.rgb_valid_o), 96'd0);
        end

        send_check("mid_grey", {8{8'h80}}, {12{8'h80}});
        send_check("clip_hi", {8'hFF, 8'h80, 8'hFF, 8'hFF, 8'hFF, 8'h80, 8'hFF, 8'hFF},
                   {4{pix(8'd255, 8'd164, 8'd255)}});
        send_check("clip_lo", {8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h80},
                   {4{pix(8'd0, 8'd44, 8'd0)}});
        send_check("chroma_pair", {8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'hFF},
                   {pix(8'd128, 8'd128, 8'd128), pix(8'd128, 8'd128, 8'd128),
                    pix(8'd255, 8'd37, 8'd128), pix(8'd255, 8'd37, 8'd128)});
        send_check("pix_order", {8'h10, 8'h80, 8'h20, 8'h80, 8'h30, 8'h80, 8'h40, 8'h80},
                   {{3{8'h10}}, {3{8'h20}}, {3{8'h30}}, {3{8'h40}}});

        // Back-to-back stream with a fixed irregular ready pattern.
        rpat       = 16'b1011_0010_0110_1101;
        sent       = 0;
        recv       = 0;
        stall_prev = 1'b0;
        held       = '0;
        for (int cyc = 0; cyc < 200 && recv < 8; cyc++) begin
            bus.yuv_valid_i = (sent < 8);
            bus.yuv_i       = beat_yuv(sent);
            bus.rgb_ready_i = rpat[cyc % 16];
            #1;
            if (stall_prev) begin
                chk("hold_valid", 96'(bus.rgb_valid_o), 96'd1);
                chk("hold_data", bus.rgb_o, held);
            end
            if (bus.rgb_valid_o && !bus.rgb_ready_i)
                chk("stall_ready", 96'(bus.yuv_ready_o), 96'd0);
            if (bus.rgb_valid_o && bus.rgb_ready_i) begin
                chk("stream_data", bus.rgb_o, beat_rgb(recv));
                recv++;
            end
            if (bus.yuv_valid_i && bus.yuv_ready_o)
                sent++;
            stall_prev = bus.rgb_valid_o && !bus.rgb_ready_i;
            held       = bus.rgb_o;
            step();
        end
        bus.yuv_valid_i = 1'b0;
        bus.rgb_ready_i = 1'b1;
        chk("stream_count", 96'(recv), 96'd8);
        step();
        step();
        step();
        chk("stream_empty", 96'(bus.rgb_valid_o), 96'd0);

        // Fill the pipeline, then pulse reset for one cycle.
        for (int i = 0; i < 3; i++) begin
            bus.yuv_i       = beat_yuv(i + 3);
            bus.yuv_valid_i = 1'b1;
            step();
        end
        bus.yuv_valid_i = 1'b0;
        reset_i         = 1'b1;
        #1;
        chk("mid_rst_ready", 96'(bus.yuv_ready_o), 96'd1);
        step();
        reset_i = 1'b0;
        chk("mid_rst_valid", 96'(bus.rgb_valid_o), 96'd0);
        chk("mid_rst_rgb", bus.rgb_o, 96'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_rst_flush", 96'(bus.rgb_valid_o), 96'd0);
        end
        send_check("post_rst", beat_yuv(9), beat_rgb(9));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
